// File: rtl/order_decode.sv
// Two-beat order message parser: validates framing, side byte and end tag,
// and presents one decoded order on a valid/ready output with error strobes.
//
// state | meaning
// W0    | expecting word 0 (side, qty); always ready
// W1    | expecting word 1 (price, tag); ready only when output slot frees
// DRAIN | discarding the rest of a malformed message up to tlast
module order_decode #(
  parameter int          DATA_W  = 64,
  parameter logic [31:0] END_TAG = 32'hEEEE_EEEE,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_buy,
  output logic [31:0]       out_qty,
  output logic [31:0]       out_px,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  msg_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    W0    = 2'd0,
    W1    = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] ERR_SHORT = 3'd1;
  localparam logic [2:0] ERR_SIDE  = 3'd2;
  localparam logic [2:0] ERR_LONG  = 3'd3;
  localparam logic [2:0] ERR_TAG   = 3'd4;

  localparam logic [7:0] SIDE_BUY  = 8'h42;
  localparam logic [7:0] SIDE_SELL = 8'h53;

  state_t      state, state_nxt;
  logic        beat;
  logic [7:0]  side;
  logic        side_ok;
  logic        tag_ok;
  logic        err_now;
  logic [2:0]  err_code_nxt;
  logic        load_stage;
  logic        load_out;
  logic        stg_buy;
  logic [31:0] stg_qty;

  // Word 1 may only land when the output slot is empty or being emptied this cycle.
  assign s_axis_tready = (state == W1) ? (!out_valid || out_ready) : 1'b1;
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign side          = s_axis_tdata[63:56];
  assign side_ok       = (side == SIDE_BUY) || (side == SIDE_SELL);
  assign tag_ok        = (s_axis_tdata[31:0] == END_TAG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= W0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    err_now      = 1'b0;
    err_code_nxt = 3'd0;
    load_stage   = 1'b0;
    load_out     = 1'b0;
    case (state)
      W0: begin
        if (beat) begin
          if (s_axis_tlast) begin
            err_now      = 1'b1;
            err_code_nxt = ERR_SHORT;
          end else if (!side_ok) begin
            err_now      = 1'b1;
            err_code_nxt = ERR_SIDE;
            state_nxt    = DRAIN;
          end else begin
            load_stage   = 1'b1;
            state_nxt    = W1;
          end
        end
      end
      W1: begin
        if (beat) begin
          if (!s_axis_tlast) begin
            err_now      = 1'b1;
            err_code_nxt = ERR_LONG;
            state_nxt    = DRAIN;
          end else if (!tag_ok) begin
            err_now      = 1'b1;
            err_code_nxt = ERR_TAG;
            state_nxt    = W0;
          end else begin
            load_out     = 1'b1;
            state_nxt    = W0;
          end
        end
      end
      DRAIN: begin
        if (beat && s_axis_tlast) state_nxt = W0;
      end
      default: state_nxt = W0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_buy <= 1'b0;
      stg_qty <= '0;
    end else if (load_stage) begin
      stg_buy <= (side == SIDE_BUY);
      stg_qty <= s_axis_tdata[55:24];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_buy   <= 1'b0;
      out_qty   <= '0;
      out_px    <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_buy   <= stg_buy;
      out_qty   <= stg_qty;
      out_px    <= s_axis_tdata[63:32];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_code  <= '0;
    end else begin
      err_valid <= err_now;
      if (err_now) err_code <= err_code_nxt;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (load_out && (msg_cnt != '1)) msg_cnt <= msg_cnt + 1'b1;
      if (err_now  && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_order_decode.sv
// Randomized scoreboard bench for order_decode: a frame-level reference model
// predicts orders and errors per accepted beat; a monitor checks the outputs.
module tb_order_decode;

  localparam int          CNT_W   = 4;
  localparam logic [31:0] END_TAG = 32'hEEEE_EEEE;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [63:0]      s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tlast;
  logic             s_axis_tready;
  logic             out_valid;
  logic             out_ready;
  logic             out_buy;
  logic [31:0]      out_qty;
  logic [31:0]      out_px;
  logic             err_valid;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] msg_cnt;
  logic [CNT_W-1:0] err_cnt;

  order_decode #(.DATA_W(64), .END_TAG(END_TAG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_buy(out_buy), .out_qty(out_qty), .out_px(out_px),
    .err_valid(err_valid), .err_code(err_code),
    .msg_cnt(msg_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    int          cyc;
    logic        buy;
    logic [31:0] qty;
    logic [31:0] px;
    int          mcnt;
  } ord_t;

  typedef struct {
    int         cyc;
    logic [2:0] code;
    int         ecnt;
  } err_t;

  ord_t oq[$];
  err_t eq[$];

  int  n_total = 0;
  int  n_pass  = 0;
  int  cyc     = 0;
  int  rmode   = 1;   // 0 random, 1 high, 2 low
  int  max_gap = 0;
  bit  in_rst  = 0;

  // frame-level model state
  int          pos   = 0;
  bit          bad   = 0;
  int          n_msg = 0;
  int          n_err = 0;
  logic        m_buy;
  logic [31:0] m_qty;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic push_err(input logic [2:0] code, input int c);
    err_t e;
    if (n_err < CMAX) n_err++;
    e.cyc = c; e.code = code; e.ecnt = n_err;
    eq.push_back(e);
  endtask

  // Classify each accepted beat by its position within the current frame.
  task automatic model_beat(input logic [63:0] d, input logic last, input int c);
    ord_t o;
    if (bad || pos >= 2) begin
      // discarded remainder of a malformed frame
    end else if (pos == 0) begin
      if (last) push_err(3'd1, c);
      else if (d[63:56] != 8'h42 && d[63:56] != 8'h53) begin
        push_err(3'd2, c);
        bad = 1;
      end else begin
        m_buy = (d[63:56] == 8'h42);
        m_qty = d[55:24];
      end
    end else begin
      if (!last) begin
        push_err(3'd3, c);
        bad = 1;
      end else if (d[31:0] != END_TAG) push_err(3'd4, c);
      else begin
        if (n_msg < CMAX) n_msg++;
        o.cyc = c; o.buy = m_buy; o.qty = m_qty; o.px = d[63:32]; o.mcnt = n_msg;
        oq.push_back(o);
      end
    end
    pos++;
    if (last) begin
      pos = 0;
      bad = 0;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = {$urandom, $urandom};
    s_axis_tlast  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    int guard = 0;
    bit acc   = 0;
    int gap   = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) idle_cycle();
    while (!acc) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      #1;
      if (s_axis_tready) begin
        acc = 1;
        model_beat(d, last, cyc + 1);
      end else if (++guard > 500) begin
        chk("tready_stall_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  function automatic logic [7:0] bad_side();
    logic [7:0] b = 8'($urandom);
    while (b == 8'h42 || b == 8'h53) b = b + 8'd1;
    return b;
  endfunction

  task automatic send_good(input bit buy, input logic [31:0] q, input logic [31:0] p);
    send_beat({(buy ? 8'h42 : 8'h53), q, 24'($urandom)}, 1'b0);
    send_beat({p, END_TAG}, 1'b1);
  endtask

  task automatic send_random_frame();
    int kind = int'($urandom_range(0, 9));
    int extra = int'($urandom_range(1, 3));
    logic [31:0] tag = $urandom;
    if (tag == END_TAG) tag = tag ^ 32'h1;
    if (kind <= 4) send_good(1'($urandom_range(0, 1)), $urandom, $urandom);
    else if (kind == 5) send_beat({8'h42, 56'($urandom)}, 1'b1);
    else if (kind == 6) begin
      send_beat({bad_side(), 56'($urandom)}, 1'b0);
      for (int i = 0; i < extra; i++) send_beat({$urandom, $urandom}, 1'(i == extra - 1));
    end else if (kind == 7) begin
      send_beat({8'h53, 56'($urandom)}, 1'b0);
      send_beat({$urandom, END_TAG}, 1'b0);
      for (int i = 0; i < extra; i++) send_beat({$urandom, $urandom}, 1'(i == extra - 1));
    end else begin
      send_beat({8'h42, 56'($urandom)}, 1'b0);
      send_beat({$urandom, tag}, 1'b1);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((oq.size() > 0 || eq.size() > 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) chk("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_err_valid"}, err_valid, 0);
    chk({tag, "_out_buy"},   out_buy,   0);
    chk({tag, "_out_qty"},   out_qty,   0);
    chk({tag, "_out_px"},    out_px,    0);
    chk({tag, "_err_code"},  err_code,  0);
    chk({tag, "_msg_cnt"},   msg_cnt,   0);
    chk({tag, "_err_cnt"},   err_cnt,   0);
  endtask

  task automatic model_clear();
    oq.delete();
    eq.delete();
    pos = 0; bad = 0; n_msg = 0; n_err = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (rmode == 0) out_ready = ($urandom_range(0, 3) != 0);
    else            out_ready = (rmode == 1);
  end

  // Monitor: samples just after the falling edge, when outputs and out_ready are settled.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && !in_rst) begin
      if (eq.size() > 0 && eq[0].cyc == cyc) begin
        chk("err_valid", err_valid, 1);
        chk("err_code",  err_code,  eq[0].code);
        chk("err_cnt",   err_cnt,   eq[0].ecnt);
        void'(eq.pop_front());
      end else if (err_valid) chk("err_spurious", err_valid, 0);
      if (out_valid) begin
        if (oq.size() == 0) chk("out_spurious", out_valid, 0);
        else begin
          chk("out_early", (oq[0].cyc <= cyc), 1);
          chk("out_buy",   out_buy,  oq[0].buy);
          chk("out_qty",   out_qty,  oq[0].qty);
          chk("out_px",    out_px,   oq[0].px);
          chk("msg_cnt",   msg_cnt,  oq[0].mcnt);
          if (out_ready) void'(oq.pop_front());
        end
      end else if (oq.size() > 0 && oq[0].cyc <= cyc) begin
        chk("out_late", out_valid, 1);
        void'(oq.pop_front());
      end
    end
  end

  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    out_ready     = 1'b1;
    rst_n         = 1'b1;
    in_rst        = 1;
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    in_rst = 0;

    // buy message with consumer always ready
    rmode = 1;
    send_beat(64'h42_00000064_000000, 1'b0);
    send_beat(64'h000186A0_EEEEEEEE, 1'b1);
    wait_drain();
    chk("buy_msg_cnt", msg_cnt, 1);

    // sell held under backpressure, second message streamed behind it
    rmode = 2;
    send_good(1'b0, 32'd250, 32'd777);
    fork
      send_good(1'b1, 32'd9, 32'd12345);
      begin
        repeat (6) @(posedge clk);
        rmode = 1;
      end
    join
    wait_drain();

    // bad tag, then a good message
    send_beat(64'h42_00000064_000000, 1'b0);
    send_beat(64'h000186A0_EEEEEEEF, 1'b1);
    send_good(1'b1, 32'd55, 32'd66);
    wait_drain();

    // short message
    send_beat(64'h53_00000001_000000, 1'b1);
    send_good(1'b0, 32'd3, 32'd4);
    wait_drain();

    // bad side followed by three drained beats
    send_beat(64'h58_00000064_000000, 1'b0);
    send_beat(64'h000186A0_EEEEEEEE, 1'b0);
    send_beat(64'h42_00000064_000000, 1'b0);
    send_beat(64'h000186A0_EEEEEEEE, 1'b1);
    send_good(1'b1, 32'd1000, 32'd2000);
    wait_drain();

    // long message
    send_beat(64'h42_00000010_000000, 1'b0);
    send_beat(64'h00000020_EEEEEEEE, 1'b0);
    send_beat(64'h00000030_EEEEEEEE, 1'b1);
    wait_drain();

    // reset with a partial message in flight
    send_beat(64'h42_00000077_000000, 1'b0);
    @(negedge clk);
    in_rst = 1;
    rst_n  = 1'b0;
    #1 check_zero("midrst");
    model_clear();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    in_rst = 0;
    send_good(1'b0, 32'd42, 32'd4242);
    wait_drain();
    chk("post_reset_msg_cnt", msg_cnt, 1);

    // saturation: 20 good messages back to back
    for (int i = 0; i < 20; i++) send_good(1'($urandom_range(0, 1)), $urandom, $urandom);
    wait_drain();
    chk("msg_cnt_sat", msg_cnt, CMAX);

    // randomized traffic with gaps and random consumer readiness
    rmode   = 0;
    max_gap = 2;
    for (int i = 0; i < 300; i++) send_random_frame();
    rmode = 1;
    wait_drain();
    chk("final_msg_cnt", msg_cnt, n_msg);
    chk("final_err_cnt", err_cnt, n_err);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
